// File: rtl/elastic_buffer_chain.sv
// Register chain moving NUM_DATA_INPUTS words per beat under one valid/ready handshake; NUM_BUFFERS cycles latency.
// Backpressure: bubble-collapsing or lockstep stalls; optional flop-driven ready with a one-entry skid slot.
module elastic_buffer_chain #(
   parameter int NUM_DATA_INPUTS  = 1,
   parameter int DATA_WIDTH       = 8,
   parameter int NUM_BUFFERS      = 2,
   parameter int COLLAPSE_BUBBLES = 1,
   parameter int REGISTERED_READY = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              data_in_valid,
   input  logic [DATA_WIDTH-1:0]             data_in [NUM_DATA_INPUTS],
   output logic                              data_in_ready,
   output logic                              data_out_valid,
   output logic [DATA_WIDTH-1:0]             data_out [NUM_DATA_INPUTS],
   input  logic                              data_out_ready,
   output logic [$clog2(NUM_BUFFERS+2)-1:0]  occupancy
);
   localparam int OW = $clog2(NUM_BUFFERS+2);

   if (NUM_BUFFERS == 0) begin : g_pass
      logic unused;
      assign unused         = clk ^ rst ^ flush;
      assign data_out_valid = data_in_valid;
      assign data_out       = data_in;
      assign data_in_ready  = data_out_ready;
      assign occupancy      = '0;
   end else begin : g_chain
      logic [NUM_BUFFERS-1:0] v;
      logic [NUM_BUFFERS-1:0] rdy;
      logic [NUM_BUFFERS-1:0] load;
      logic [DATA_WIDTH-1:0]  sd [NUM_BUFFERS][NUM_DATA_INPUTS];
      logic                   shift;
      logic                   in_rdy;
      logic                   in_xfer;
      logic                   out_xfer;
      logic                   src_vld;
      logic [DATA_WIDTH-1:0]  src_dat [NUM_DATA_INPUTS];
      logic [OW-1:0]          occ;

      // Ready ripples from the output end; built without self-reference to keep the net acyclic.
      always_comb begin
         logic r;
         rdy = '0;
         r   = data_out_ready;
         for (int i = NUM_BUFFERS-1; i >= 0; i--) begin
            r      = ~v[i] | r;
            rdy[i] = r;
         end
      end

      assign shift = ~v[NUM_BUFFERS-1] | data_out_ready;
      assign load  = (COLLAPSE_BUBBLES != 0) ? rdy : {NUM_BUFFERS{shift}};

      for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_stage
         logic                  pv;
         logic                  vld;
         logic [DATA_WIDTH-1:0] pd  [NUM_DATA_INPUTS];
         logic [DATA_WIDTH-1:0] dat [NUM_DATA_INPUTS];

         if (i == 0) begin : g_head
            assign pv = src_vld;
            assign pd = src_dat;
         end else begin : g_body
            assign pv = v[i-1];
            assign pd = sd[i-1];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               vld <= 1'b0;
               dat <= '{default: '0};
            end else if (flush) begin
               vld <= 1'b0;
            end else if (load[i]) begin
               vld <= pv;
               if (pv) dat <= pd;
            end
         end

         assign v[i]  = vld;
         assign sd[i] = dat;
      end

      if (REGISTERED_READY != 0) begin : g_skid
         logic                  skid_vld;
         logic [DATA_WIDTH-1:0] skid_dat [NUM_DATA_INPUTS];

         // A held skid beat always feeds stage 0 ahead of new input, preserving order.
         always_ff @(posedge clk) begin
            if (rst) begin
               skid_vld <= 1'b0;
               skid_dat <= '{default: '0};
            end else if (flush) begin
               skid_vld <= 1'b0;
            end else if (skid_vld) begin
               if (load[0]) skid_vld <= 1'b0;
            end else if (in_xfer && !load[0]) begin
               skid_vld <= 1'b1;
               skid_dat <= data_in;
            end
         end

         always_comb begin
            for (int w = 0; w < NUM_DATA_INPUTS; w++)
               src_dat[w] = skid_vld ? skid_dat[w] : data_in[w];
         end

         assign in_rdy  = ~skid_vld;
         assign src_vld = skid_vld | data_in_valid;
      end else begin : g_direct
         assign in_rdy  = load[0];
         assign src_vld = data_in_valid;
         assign src_dat = data_in;
      end

      assign data_in_ready  = in_rdy & ~rst & ~flush;
      assign data_out_valid = v[NUM_BUFFERS-1] & ~rst & ~flush;
      assign data_out       = sd[NUM_BUFFERS-1];
      assign in_xfer        = data_in_valid & data_in_ready;
      assign out_xfer       = data_out_valid & data_out_ready;

      always_ff @(posedge clk) begin
         if (rst || flush)
            occ <= '0;
         else if (in_xfer && !out_xfer)
            occ <= occ + OW'(1);
         else if (!in_xfer && out_xfer)
            occ <= occ - OW'(1);
      end

      assign occupancy = occ;
   end
endmodule

// File: tb/tb_elastic_buffer_chain.sv
// Directed checks of elastic_buffer_chain builds: latency, bubble collapse, lockstep, skid, flush, passthrough.
module tb_elastic_buffer_chain;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // a: N=3 bubble-collapsing, b: N=3 lockstep, c: N=2 skid, e: N=4 flush, p: N=0 passthrough
   logic       a_flush, a_ivld, a_irdy, a_ovld, a_ordy;
   logic [7:0] a_din [1];
   logic [7:0] a_dout [1];
   logic [2:0] a_occ;
   logic       b_flush, b_ivld, b_irdy, b_ovld, b_ordy;
   logic [7:0] b_din [1];
   logic [7:0] b_dout [1];
   logic [2:0] b_occ;
   logic       c_flush, c_ivld, c_irdy, c_ovld, c_ordy;
   logic [7:0] c_din [2];
   logic [7:0] c_dout [2];
   logic [1:0] c_occ;
   logic       e_flush, e_ivld, e_irdy, e_ovld, e_ordy;
   logic [7:0] e_din [1];
   logic [7:0] e_dout [1];
   logic [2:0] e_occ;
   logic       p_flush, p_ivld, p_irdy, p_ovld, p_ordy;
   logic [7:0] p_din [4];
   logic [7:0] p_dout [4];
   logic [0:0] p_occ;

   elastic_buffer_chain #(.NUM_DATA_INPUTS(1), .DATA_WIDTH(8), .NUM_BUFFERS(3),
                          .COLLAPSE_BUBBLES(1), .REGISTERED_READY(0)) u_a (
      .clk(clk), .rst(rst), .flush(a_flush), .data_in_valid(a_ivld), .data_in(a_din),
      .data_in_ready(a_irdy), .data_out_valid(a_ovld), .data_out(a_dout),
      .data_out_ready(a_ordy), .occupancy(a_occ));

   elastic_buffer_chain #(.NUM_DATA_INPUTS(1), .DATA_WIDTH(8), .NUM_BUFFERS(3),
                          .COLLAPSE_BUBBLES(0), .REGISTERED_READY(0)) u_b (
      .clk(clk), .rst(rst), .flush(b_flush), .data_in_valid(b_ivld), .data_in(b_din),
      .data_in_ready(b_irdy), .data_out_valid(b_ovld), .data_out(b_dout),
      .data_out_ready(b_ordy), .occupancy(b_occ));

   elastic_buffer_chain #(.NUM_DATA_INPUTS(2), .DATA_WIDTH(8), .NUM_BUFFERS(2),
                          .COLLAPSE_BUBBLES(1), .REGISTERED_READY(1)) u_c (
      .clk(clk), .rst(rst), .flush(c_flush), .data_in_valid(c_ivld), .data_in(c_din),
      .data_in_ready(c_irdy), .data_out_valid(c_ovld), .data_out(c_dout),
      .data_out_ready(c_ordy), .occupancy(c_occ));

   elastic_buffer_chain #(.NUM_DATA_INPUTS(1), .DATA_WIDTH(8), .NUM_BUFFERS(4),
                          .COLLAPSE_BUBBLES(1), .REGISTERED_READY(0)) u_e (
      .clk(clk), .rst(rst), .flush(e_flush), .data_in_valid(e_ivld), .data_in(e_din),
      .data_in_ready(e_irdy), .data_out_valid(e_ovld), .data_out(e_dout),
      .data_out_ready(e_ordy), .occupancy(e_occ));

   elastic_buffer_chain #(.NUM_DATA_INPUTS(4), .DATA_WIDTH(8), .NUM_BUFFERS(0),
                          .COLLAPSE_BUBBLES(1), .REGISTERED_READY(0)) u_p (
      .clk(clk), .rst(rst), .flush(p_flush), .data_in_valid(p_ivld), .data_in(p_din),
      .data_in_ready(p_irdy), .data_out_valid(p_ovld), .data_out(p_dout),
      .data_out_ready(p_ordy), .occupancy(p_occ));

   localparam logic [31:0] LAT_VLD  [8]  = '{0, 0, 0, 1, 1, 1, 0, 0};
   localparam logic [31:0] LAT_DAT  [8]  = '{0, 0, 0, 'h11, 'h22, 'h33, 0, 0};
   localparam logic [31:0] LAT_OCC  [8]  = '{0, 1, 2, 3, 2, 1, 0, 0};
   localparam logic [31:0] BUB_VLD  [8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
   localparam logic [31:0] BUB_DAT  [8]  = '{0, 0, 0, 'hA1, 'hA1, 'hA2, 'hA3, 0};
   localparam logic [31:0] BUB_OCC  [8]  = '{0, 1, 2, 3, 3, 2, 1, 0};
   localparam logic [31:0] BUB_IRDY [8]  = '{1, 1, 1, 0, 1, 1, 1, 1};
   localparam logic [31:0] LCK_VLD  [9]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
   localparam logic [31:0] LCK_DAT  [9]  = '{0, 0, 0, 'h51, 'h51, 'h51, 0, 'h52, 0};
   localparam logic [31:0] LCK_OCC  [9]  = '{0, 1, 1, 2, 2, 2, 1, 1, 0};
   localparam logic [31:0] LCK_IRDY [9]  = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
   localparam logic [31:0] FL_VLD   [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   localparam logic [31:0] FL_OCC   [11] = '{0, 1, 2, 3, 4, 0, 1, 1, 1, 1, 0};
   localparam logic [31:0] FL_IRDY  [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
   localparam logic [31:0] PT_DAT   [3]  = '{32'hDEADBEEF, 32'h01234567, 32'hA5A55A5A};

   int          peak;
   int          sent;
   int          got;
   logic        c_acc;
   logic        irdy_edge;
   logic [15:0] tmp;
   logic [15:0] exp16;
   logic [15:0] sb [$];

   initial begin
      rst = 1'b1;
      a_flush = 0; a_ivld = 0; a_ordy = 0; a_din[0] = '0;
      b_flush = 0; b_ivld = 0; b_ordy = 0; b_din[0] = '0;
      c_flush = 0; c_ivld = 0; c_ordy = 0; c_din[0] = '0; c_din[1] = '0;
      e_flush = 0; e_ivld = 0; e_ordy = 0; e_din[0] = '0;
      p_flush = 0; p_ivld = 0; p_ordy = 0;
      for (int j = 0; j < 4; j++) p_din[j] = '0;

      @(negedge clk);
      check_val("rst_a_ovld", 32'(a_ovld), 0);
      check_val("rst_a_occ",  32'(a_occ),  0);
      check_val("rst_a_dout", 32'(a_dout[0]), 0);
      check_val("rst_a_irdy", 32'(a_irdy), 0);
      check_val("rst_b_irdy", 32'(b_irdy), 0);
      check_val("rst_c_irdy", 32'(c_irdy), 0);
      check_val("rst_c_ovld", 32'(c_ovld), 0);
      check_val("rst_c_dout", {16'h0, c_dout[1], c_dout[0]}, 0);
      check_val("rst_e_occ",  32'(e_occ),  0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_a_irdy", 32'(a_irdy), 1);
      check_val("post_rst_b_irdy", 32'(b_irdy), 1);
      check_val("post_rst_c_irdy", 32'(c_irdy), 1);
      check_val("post_rst_e_irdy", 32'(e_irdy), 1);
      next_cycle();

      // latency: three back-to-back beats through three stages
      a_ordy = 1;
      peak   = 0;
      for (int k = 0; k < 8; k++) begin
         a_ivld   = (k < 3);
         a_din[0] = 8'((k + 1) * 'h11);
         @(negedge clk);
         check_val("lat_ovld", 32'(a_ovld), LAT_VLD[k]);
         if (LAT_VLD[k] != 0) check_val("lat_dout", 32'(a_dout[0]), LAT_DAT[k]);
         check_val("lat_occ", 32'(a_occ), LAT_OCC[k]);
         check_val("lat_irdy", 32'(a_irdy), 1);
         if (int'(a_occ) > peak) peak = int'(a_occ);
         next_cycle();
      end
      check_val("lat_peak", 32'(peak), 3);

      // bubble collapse: stall output, fill all stages, then drain
      for (int k = 0; k < 8; k++) begin
         a_ivld   = (k < 3);
         a_din[0] = 8'('hA1 + k);
         a_ordy   = (k >= 4);
         @(negedge clk);
         check_val("bub_ovld", 32'(a_ovld), BUB_VLD[k]);
         if (BUB_VLD[k] != 0) check_val("bub_dout", 32'(a_dout[0]), BUB_DAT[k]);
         check_val("bub_occ", 32'(a_occ), BUB_OCC[k]);
         check_val("bub_irdy", 32'(a_irdy), BUB_IRDY[k]);
         next_cycle();
      end

      // lockstep: valid pattern 1,0,1 with a two-cycle stall at the output
      for (int k = 0; k < 9; k++) begin
         b_ivld   = (k == 0 || k == 2);
         b_din[0] = (k == 0) ? 8'h51 : 8'h52;
         b_ordy   = !(k == 3 || k == 4);
         @(negedge clk);
         check_val("lck_ovld", 32'(b_ovld), LCK_VLD[k]);
         if (LCK_VLD[k] != 0) check_val("lck_dout", 32'(b_dout[0]), LCK_DAT[k]);
         check_val("lck_occ", 32'(b_occ), LCK_OCC[k]);
         check_val("lck_irdy", 32'(b_irdy), LCK_IRDY[k]);
         next_cycle();
      end

      // flush: fill four stages, flush, then time a fresh beat
      for (int k = 0; k < 11; k++) begin
         e_ivld   = (k < 6);
         e_din[0] = (k < 4) ? 8'('h61 + k) : 8'h70;
         e_ordy   = (k >= 5);
         e_flush  = (k == 4);
         @(negedge clk);
         check_val("fl_ovld", 32'(e_ovld), FL_VLD[k]);
         if (FL_VLD[k] != 0) check_val("fl_dout", 32'(e_dout[0]), 32'h70);
         check_val("fl_occ", 32'(e_occ), FL_OCC[k]);
         check_val("fl_irdy", 32'(e_irdy), FL_IRDY[k]);
         next_cycle();
      end
      e_ivld = 0;

      // passthrough: same-cycle data/valid/ready, flush ignored
      for (int k = 0; k < 3; k++) begin
         logic [31:0] w;
         w = PT_DAT[k];
         for (int j = 0; j < 4; j++) p_din[j] = w[8*j +: 8];
         p_ivld  = (k != 1);
         p_ordy  = (k != 2);
         p_flush = (k == 1);
         #1;
         check_val("pt_data", {p_dout[3], p_dout[2], p_dout[1], p_dout[0]}, w);
         check_val("pt_ovld", 32'(p_ovld), 32'(p_ivld));
         check_val("pt_irdy", 32'(p_irdy), 32'(p_ordy));
         check_val("pt_occ", 32'(p_occ), 0);
         next_cycle();
      end

      // skid: random valid/ready, scoreboard ordering and occupancy tracking
      sent  = 0;
      got   = 0;
      c_acc = 1'b0;
      for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
         irdy_edge = c_irdy;
         if (!c_ivld || c_acc) begin
            if (sent < 10000) begin
               c_ivld   = 1'($urandom_range(0, 1));
               tmp      = sent[15:0];
               c_din[0] = tmp[7:0];
               c_din[1] = tmp[15:8];
            end else begin
               c_ivld = 1'b0;
            end
         end
         c_ordy = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_val("skid_irdy_stable", 32'(c_irdy), 32'(irdy_edge));
         check_val("skid_occ", 32'(c_occ), 32'(sb.size()));
         check_val("skid_occ_max", 32'(sb.size() > 3), 0);
         c_acc = c_ivld && c_irdy;
         if (c_acc) begin
            sb.push_back({c_din[1], c_din[0]});
            sent++;
         end
         if (c_ovld && c_ordy) begin
            if (sb.size() == 0) begin
               check_val("skid_underflow", {16'h0, c_dout[1], c_dout[0]}, 32'hFFFF_FFFF);
            end else begin
               exp16 = sb.pop_front();
               check_val("skid_data", {16'h0, c_dout[1], c_dout[0]}, {16'h0, exp16});
            end
            got++;
         end
         next_cycle();
      end
      check_val("skid_count", 32'(got), 10000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/elastic_buffer_chain.md
# elastic_buffer_chain

Parametrised successor to the intermediate data buffer. It is a chain of zero or more register stages carrying `NUM_DATA_INPUTS` parallel words under one valid/ready handshake. Per-build options:
- lockstep (time-order-preserving) or bubble-collapsing advance;
- an optional registered `data_in_ready` backed by a one-entry skid slot.

Synchronous reset, synchronous flush and an occupancy count are provided. It sits between neuralConnect processing stages to break long valid/ready and data paths.

## Interface
- `NUM_DATA_INPUTS`, 1, parallel words per beat (≥1)
- `DATA_WIDTH`, 8, bits per word (≥1)
- `NUM_BUFFERS`, 2, register stages in the chain; 0 = combinational passthrough
- `COLLAPSE_BUBBLES`, 1, 1 = stages advance independently; 0 = whole chain advances in lockstep
- `REGISTERED_READY`, 0, 1 = `data_in_ready` driven straight from a flop, with a skid slot; ignored when `NUM_BUFFERS`=0
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  synchronous clear of all stored beats
- `data_in_valid`  in  1  upstream beat valid
- `data_in`  in  `DATA_WIDTH` × `NUM_DATA_INPUTS` (unpacked)  upstream words
- `data_in_ready`  out  1  block accepts beat this cycle
- `data_out_valid`  out  1  last stage holds a beat
- `data_out`  out  `DATA_WIDTH` × `NUM_DATA_INPUTS`  last-stage words
- `data_out_ready`  in  1  downstream accepts
- `occupancy`  out  `$clog2(NUM_BUFFERS+2)`  stored beats (stages + skid slot), registered

## Operation
- Handshake: a transfer occurs on a cycle with valid & ready both high. Words never change while valid is high and ready is low. No beat is dropped, duplicated or reordered.
- Definitions: `v[i]` is stage i's valid bit, where i=0 is the input end and i=N-1 the output end. `rdy[N]` = `data_out_ready`.
- `COLLAPSE_BUBBLES`=1:
  - `rdy[i]` = ~`v[i]` | `rdy[i+1]`.
  - Stage i loads stage i-1 (stage 0 loads the input source) when `rdy[i]`.
  - It takes the upstream valid bit; data registers update only when the incoming valid is 1.
- `COLLAPSE_BUBBLES`=0:
  - shift = ~`v[N-1]` | `data_out_ready`.
  - On shift, every stage loads its predecessor, valid included, so bubbles are preserved.
  - On no shift, all stages hold.
- Input source, `REGISTERED_READY`=0: `data_in_ready` = `rdy[0]` (bubble mode) or shift (lockstep), combinationally.
- Input source, `REGISTERED_READY`=1:
  - `data_in_ready` = ~skid_valid, registered.
  - An accepted beat goes to stage 0 if stage 0 loads this cycle, otherwise into the skid slot.
  - While the skid slot is full, it is stage 0's source with priority and input is refused.
  - The skid slot empties on the cycle stage 0 loads it.
- `flush`:
  - During the flush cycle, `data_in_ready`=0 and `data_out_valid`=0, so no handshake occurs.
  - On the next edge, all valid bits and the skid slot clear and `occupancy` becomes 0.
  - Data registers keep stale contents.
- `rst` has priority over `flush`. `NUM_BUFFERS`=0 gives a pure wire passthrough with `occupancy`=0; `rst` and `flush` have no effect.

## Timing
- Reset values: all valid bits 0, skid 0, data regs 0. `data_out_valid`=0, `occupancy`=0, `data_out`=0.
- `data_in_ready` is 0 while `rst` is high. It is 1 in the first cycle after `rst` deasserts, in every mode.
- Latency: with an empty chain and `data_out_ready`=1, a beat accepted at cycle t appears as `data_out_valid` at t+`NUM_BUFFERS`. The skid slot adds no latency when stage 0 is free.
- Throughput: 1 beat/cycle sustained while `data_out_ready`=1, in all modes.
- Capacity:
  - Bubble mode fills all N stages under stall.
  - Lockstep mode accepts nothing while the last stage stalls.
  - The skid slot adds exactly 1 entry.
- `occupancy` updates on the edge after the change: +1 on accept only, -1 on output only, unchanged on both or neither.
- Reset or flush mid-stream: in-flight beats are discarded. Upstream must re-present unaccepted beats.

## Test plan
- Reset and latency: `NUM_BUFFERS`=3, `data_out_ready`=1. Drive beats 0x11, 0x22, 0x33 on consecutive cycles from cycle 0. Required: the same values out on cycles 3, 4, 5, and `occupancy` peaks at 3.
- Bubble collapse: N=3, `COLLAPSE_BUBBLES`=1. Send one beat, hold `data_out_ready`=0, then send 2 more. Required: `occupancy`=3, `data_in_ready`=0; on release the beats drain back-to-back in order.
- Lockstep order: N=3, `COLLAPSE_BUBBLES`=0. Input pattern valid 1,0,1 with a stall of 2 cycles when the first beat reaches the output. Required: the output valid pattern is 1,0,1 (gap preserved), and `data_in_ready`=0 during the stall.
- Skid: N=2, `REGISTERED_READY`=1, random valid and ready at 50% each for 10,000 beats with incrementing data. Required:
  - the scoreboard matches in order;
  - `occupancy` is never above 3;
  - `data_in_ready` never changes except on a clock edge.
- Flush: fill N=4 to `occupancy` 4 with `data_out_ready`=0, then assert `flush` for 1 cycle. Required: `data_out_valid`=0 and `data_in_ready`=0 in the flush cycle; next cycle `occupancy`=0; the next beat sent appears 4 cycles after acceptance.
- Passthrough: N=0 with `NUM_DATA_INPUTS`=4. Required: `data_out` equals `data_in` and `data_in_ready` equals `data_out_ready` in the same cycle, and `occupancy` stays 0.
